// File: rtl/parser_pkg.sv
// parser_pkg: shared widths, tag bit positions, insert FSM states and a unit-mask helper
// for the deparser-side head insertion stage.
//   HEAD_WIDTH/SHIFT_WIDTH: slice width and insertion granule ("unit"), bits
//   TAG_*_BIT: absolute bit positions of the tag flags above the slice data
package parser_pkg;

    localparam int unsigned HEAD_WIDTH       = 512;
    localparam int unsigned TAG_WIDTH        = 8;
    localparam int unsigned SHIFT_WIDTH      = 64;
    localparam int unsigned HEAD_CANDI_NUM   = HEAD_WIDTH / SHIFT_WIDTH;
    localparam int unsigned HEAD_SHIFT_WIDTH = 3;

    localparam int unsigned INS_LEN_WIDTH  = HEAD_SHIFT_WIDTH;
    localparam int unsigned TAIL_LEN_WIDTH = HEAD_SHIFT_WIDTH + 1;

    // Tag field sits directly above the data: bit 0 VALID, bit 1 START, bit 2 TAIL.
    localparam int unsigned TAG_VALID_BIT = HEAD_WIDTH + 0;
    localparam int unsigned TAG_START_BIT = HEAD_WIDTH + 1;
    localparam int unsigned TAG_TAIL_BIT  = HEAD_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        EXTRA
    } ins_state_e;

    // Ones over the top n units of a slice, zeros below; n = HEAD_CANDI_NUM gives all ones.
    function automatic logic [HEAD_WIDTH-1:0] top_units_mask(input logic [TAIL_LEN_WIDTH-1:0] n);
        return ~({HEAD_WIDTH{1'b1}} >> (32'(n) * SHIFT_WIDTH));
    endfunction

endpackage

// File: rtl/ins_head_shifter.sv
// ins_head_shifter: combinational slice mux over the eight unit offsets.
//   hi      in   HEAD_WIDTH     MSB-aligned units placed at the top of the result
//   lo      in   HEAD_WIDTH     slice shifted right by len units below them
//   len     in   INS_LEN_WIDTH  number of units taken from hi (0 = pass lo through)
//   shifted out  HEAD_WIDTH     {hi[top len units], lo[top HEAD_CANDI_NUM-len units]}
module ins_head_shifter
    import parser_pkg::*;
(
    input  logic [HEAD_WIDTH-1:0]    hi,
    input  logic [HEAD_WIDTH-1:0]    lo,
    input  logic [INS_LEN_WIDTH-1:0] len,
    output logic [HEAD_WIDTH-1:0]    shifted
);

    always_comb begin
        shifted = lo;
        for (int k = 1; k < int'(HEAD_CANDI_NUM); k++) begin
            if (len == INS_LEN_WIDTH'(k)) begin
                shifted = (hi & top_units_mask(TAIL_LEN_WIDTH'(k)))
                        | (lo >> (k * SHIFT_WIDTH));
            end
        end
    end

endmodule

// File: rtl/insert_restore_head.sv
// insert_restore_head: re-inserts a per-packet block of restored header units in front of
// the packet head stream, shifting every slice right by insLen units. When the inserted
// units overflow the last slice an extra tail slice is emitted and input is back-pressured.
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_head        input slice + tag (VALID/START/TAIL)
//   i_tailLen     valid units in the input tail slice (1..8), sampled on TAIL
//   i_insLen      units to insert (0..7), sampled on START
//   i_insData     insert units, MSB-aligned, sampled on START
//   o_ready       input beat accepted when VALID & o_ready
//   o_head        registered output slice + tag
//   o_tailLen     valid units in the output tail slice, valid with TAIL
//   i_ready       downstream accepts o_head when VALID & i_ready
// Configuration: define INS_HEAD_ZERO_PAD_EN to force units of a tail slice beyond
// o_tailLen to zero; otherwise they carry whatever the shift produced.
module insert_restore_head
    import parser_pkg::*;
(
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
    input  logic [TAIL_LEN_WIDTH-1:0]      i_tailLen,
    input  logic [INS_LEN_WIDTH-1:0]       i_insLen,
    input  logic [HEAD_WIDTH-1:0]          i_insData,
    output logic                           o_ready,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
    output logic [TAIL_LEN_WIDTH-1:0]      o_tailLen,
    input  logic                           i_ready
);

    localparam logic [TAIL_LEN_WIDTH-1:0] FULL_UNITS = TAIL_LEN_WIDTH'(HEAD_CANDI_NUM);

    ins_state_e                    state_q, state_d;
    logic [HEAD_WIDTH-1:0]         carry_q, carry_d;     // low units of last beat, MSB-aligned
    logic [INS_LEN_WIDTH-1:0]      ins_len_q, ins_len_d;
    logic [TAIL_LEN_WIDTH-1:0]     extra_len_q, extra_len_d;
    logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_q, head_d;
    logic [TAIL_LEN_WIDTH-1:0]     tail_len_q, tail_len_d;

    logic [HEAD_WIDTH-1:0]    in_data;
    logic                     in_valid, in_start, in_tail;
    logic                     accept, new_pkt;
    logic [INS_LEN_WIDTH-1:0] eff_len;
    logic [HEAD_WIDTH-1:0]    shift_hi, shifted, carry_next;
    logic [TAIL_LEN_WIDTH-1:0] sum_len;
    logic                     unused_tag;

    function automatic logic [HEAD_WIDTH-1:0] pad_tail(input logic [HEAD_WIDTH-1:0] data,
                                                       input logic [TAIL_LEN_WIDTH-1:0] n);
`ifdef INS_HEAD_ZERO_PAD_EN
        return data & top_units_mask(n);
`else
        return (n == '0) ? data : data;
`endif
    endfunction

    assign in_data    = i_head[HEAD_WIDTH-1:0];
    assign in_valid   = i_head[TAG_VALID_BIT];
    assign in_start   = i_head[TAG_START_BIT];
    assign in_tail    = i_head[TAG_TAIL_BIT];
    assign unused_tag = ^i_head[HEAD_WIDTH+TAG_WIDTH-1:TAG_TAIL_BIT+1];

    assign o_ready = i_ready & ~i_rst & (state_q != EXTRA);
    assign accept  = in_valid & o_ready;
    // A START beat opens a packet from any state except EXTRA (which never accepts).
    assign new_pkt = in_start & (state_q != EXTRA);

    assign eff_len    = new_pkt ? i_insLen : ins_len_q;
    assign shift_hi   = new_pkt ? i_insData : carry_q;
    assign carry_next = in_data << (SHIFT_WIDTH * (HEAD_CANDI_NUM - 32'(eff_len)));
    assign sum_len    = i_tailLen + {1'b0, eff_len};

    ins_head_shifter u_shifter (
        .hi      (shift_hi),
        .lo      (in_data),
        .len     (eff_len),
        .shifted (shifted)
    );

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        ins_len_d   = ins_len_q;
        extra_len_d = extra_len_q;
        head_d      = head_q;
        tail_len_d  = tail_len_q;

        if (i_ready) begin
            head_d[HEAD_WIDTH +: TAG_WIDTH] = '0;
            if (state_q == EXTRA) begin
                // Overflow slice: carried units on top, low part is don't-care filler.
                head_d[HEAD_WIDTH-1:0]  = pad_tail(shifted, extra_len_q);
                head_d[TAG_VALID_BIT]   = 1'b1;
                head_d[TAG_TAIL_BIT]    = 1'b1;
                tail_len_d              = extra_len_q;
                state_d                 = IDLE;
            end else if (accept && (new_pkt || state_q == BODY)) begin
                head_d[HEAD_WIDTH-1:0]  = shifted;
                head_d[TAG_VALID_BIT]   = 1'b1;
                head_d[TAG_START_BIT]   = in_start;
                carry_d                 = carry_next;
                ins_len_d               = eff_len;
                state_d                 = BODY;
                if (in_tail) begin
                    if (sum_len <= FULL_UNITS) begin
                        head_d[HEAD_WIDTH-1:0] = pad_tail(shifted, sum_len);
                        head_d[TAG_TAIL_BIT]   = 1'b1;
                        tail_len_d             = sum_len;
                        state_d                = IDLE;
                    end else begin
                        extra_len_d = sum_len - FULL_UNITS;
                        state_d     = EXTRA;
                    end
                end
            end
            // Non-START beat while IDLE is dropped: only the tag clear above applies.
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            carry_q     <= '0;
            ins_len_q   <= '0;
            extra_len_q <= '0;
            head_q      <= '0;
            tail_len_q  <= '0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            ins_len_q   <= ins_len_d;
            extra_len_q <= extra_len_d;
            head_q      <= head_d;
            tail_len_q  <= tail_len_d;
        end
    end

    assign o_head    = head_q;
    assign o_tailLen = tail_len_q;

endmodule

// File: tb/tb_insert_restore_head.sv
// Self-checking bench for insert_restore_head. Reference: the output stream of a packet is
// the inserted units followed by every valid input unit, cut into 8-unit slices.
module tb_insert_restore_head;
    import parser_pkg::*;

    localparam int HW = HEAD_WIDTH;
    localparam int TW = TAG_WIDTH;
    localparam int SW = SHIFT_WIDTH;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [HW+TW-1:0]  i_head = '0;
    logic [3:0]        i_tailLen = '0;
    logic [2:0]        i_insLen = '0;
    logic [HW-1:0]     i_insData = '0;
    logic              o_ready;
    logic [HW+TW-1:0]  o_head;
    logic [3:0]        o_tailLen;
    logic              i_ready = 1'b1;

    always #5 i_clk = ~i_clk;

    insert_restore_head dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_head    (i_head),
        .i_tailLen (i_tailLen),
        .i_insLen  (i_insLen),
        .i_insData (i_insData),
        .o_ready   (o_ready),
        .o_head    (o_head),
        .o_tailLen (o_tailLen),
        .i_ready   (i_ready)
    );

    typedef struct {
        logic [HW-1:0] data;
        logic          start;
        logic          tail;
        logic [3:0]    tlen;
    } beat_t;

    int total = 0;
    int bad = 0;
    beat_t cap_q[$];
    int ready_lows = 0;
    logic stall_en = 1'b0;
    logic [HW+TW-1:0] prev_head = '0;
    logic prev_ready = 1'b1;
    logic prev_ok = 1'b0;

    task automatic check(input string tag, input logic [HW+TW-1:0] obs,
                         input logic [HW+TW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream monitor: a beat is consumed at the edge following a negedge with
    // VALID & i_ready; a stalled edge must leave o_head untouched.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (prev_ok && !prev_ready) check("hold", o_head, prev_head);
            if (i_ready && !o_ready) ready_lows++;
            if (i_ready && o_head[TAG_VALID_BIT])
                cap_q.push_back('{o_head[HW-1:0], o_head[TAG_START_BIT],
                                  o_head[TAG_TAIL_BIT], o_tailLen});
        end
        prev_head  = o_head;
        prev_ready = i_ready;
        prev_ok    = !i_rst;
    end

    function automatic logic [HW-1:0] rand_slice();
        logic [HW-1:0] s;
        for (int i = 0; i < HW / 32; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    function automatic logic [63:0] unit_of(input logic [HW-1:0] s, input int u);
        return s[HW-1-SW*u -: SW];
    endfunction

    task automatic send_beat(input logic [HW-1:0] d, input logic st, input logic tl_flag,
                             input logic [3:0] tl, input logic [2:0] il,
                             input logic [HW-1:0] idata, output logic ok);
        i_head    = {5'b0, tl_flag, st, 1'b1, d};
        i_tailLen = tl;
        i_insLen  = il;
        i_insData = idata;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            i_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge i_clk);
            if (o_ready) ok = 1'b1;
            @(posedge i_clk);
            #1;
        end
        i_head = '0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 4; k++) begin
            i_ready = stall_en ? ($urandom_range(0, 1) != 0) : 1'b1;
            @(posedge i_clk);
            #1;
        end
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic compare(input logic [63:0] units[$], input int nb);
        int n;
        int nbeats;
        int nv;
        logic [HW-1:0] e;
        logic [HW-1:0] m;
        n = units.size();
        nbeats = (n + 7) / 8;
        check("beat_count", cap_q.size(), nbeats);
        for (int i = 0; i < nbeats && i < cap_q.size(); i++) begin
            nv = (i == nbeats - 1) ? n - 8 * i : 8;
            e = '0;
            m = '0;
            for (int u = 0; u < nv; u++) begin
                e[HW-1-SW*u -: SW] = units[8*i+u];
                m[HW-1-SW*u -: SW] = '1;
            end
            check("start_flag", cap_q[i].start, i == 0);
            check("tail_flag", cap_q[i].tail, i == nbeats - 1);
            check("data", cap_q[i].data & m, e);
            if (i == nbeats - 1) check("tail_len", cap_q[i].tlen, nv);
`ifdef INS_HEAD_ZERO_PAD_EN
            if (i == nbeats - 1) check("zero_pad", cap_q[i].data & ~m, 0);
`endif
        end
        check("ready_low_cycles", ready_lows, (nbeats > nb) ? 1 : 0);
    endtask

    task automatic send_packet(input int nb, input logic [2:0] il, input logic [3:0] tl,
                               input logic [HW-1:0] idata);
        logic [63:0] units[$];
        logic [HW-1:0] d;
        logic ok;
        cap_q.delete();
        ready_lows = 0;
        for (int u = 0; u < int'(il); u++) units.push_back(unit_of(idata, u));
        for (int b = 0; b < nb; b++) begin
            d = rand_slice();
            for (int u = 0; u < ((b == nb - 1) ? int'(tl) : 8); u++)
                units.push_back(unit_of(d, u));
            send_beat(d, b == 0, b == nb - 1, tl, il, idata, ok);
            if (b == 0 && ok) begin
                check("latency_valid", o_head[TAG_VALID_BIT], 1);
                check("latency_start", o_head[TAG_START_BIT], 1);
            end
        end
        drain();
        compare(units, nb);
    endtask

    initial begin
        logic ok;
        logic [HW-1:0] aa;

        // Reset state
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk);
            #1;
        end
        check("rst_head", o_head, 0);
        check("rst_tail_len", o_tailLen, 0);
        check("rst_ready", o_ready, 0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // 1: single START+TAIL beat
        aa = {8{64'hAAAA_AAAA_AAAA_AAAA}};
        send_packet(1, 3'd2, 4'd4, aa);

        // Non-START beat while idle is dropped
        cap_q.delete();
        send_beat(rand_slice(), 1'b0, 1'b1, 4'd5, 3'd1, rand_slice(), ok);
        drain();
        check("idle_drop", cap_q.size(), 0);

        // 2: overflow into an extra tail slice
        send_packet(3, 3'd3, 4'd7, rand_slice());
        // 3: passthrough
        send_packet(5, 3'd0, 4'd8, rand_slice());
        // 4: downstream stalls
        stall_en = 1'b1;
        send_packet(4, 3'd5, 4'd6, rand_slice());
        stall_en = 1'b0;

        // 5: reset mid-packet, then remaining beats are dropped, next packet clean
        send_beat(rand_slice(), 1'b1, 1'b0, 4'd3, 3'd5, rand_slice(), ok);
        i_rst  = 1'b1;
        i_head = {5'b0, 1'b0, 1'b0, 1'b1, rand_slice()};
        @(posedge i_clk);
        #1;
        check("midrst_head", o_head, 0);
        check("midrst_tail_len", o_tailLen, 0);
        check("midrst_ready", o_ready, 0);
        i_rst = 1'b0;
        cap_q.delete();
        send_beat(rand_slice(), 1'b0, 1'b0, 4'd3, 3'd5, rand_slice(), ok);
        send_beat(rand_slice(), 1'b0, 1'b1, 4'd3, 3'd5, rand_slice(), ok);
        drain();
        check("midrst_no_tail", cap_q.size(), 0);
        send_packet(2, 3'd5, 4'd3, rand_slice());

        // START while in BODY aborts the open packet; the new one is emitted intact
        send_beat(rand_slice(), 1'b1, 1'b0, 4'd2, 3'd6, rand_slice(), ok);
        @(posedge i_clk);
        #1;
        send_packet(2, 3'd4, 4'd7, rand_slice());

        // Randomized packets
        for (int p = 0; p < 25; p++) begin
            stall_en = ($urandom_range(0, 1) == 1);
            send_packet($urandom_range(1, 4), 3'($urandom_range(0, 7)),
                        4'($urandom_range(1, 8)), rand_slice());
        end
        stall_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
